// File: rtl/led_blinker_pkg.sv
// Shared definitions for the LED blinker.
//   - sel_e        : decode of the {switch_1, switch_2} frequency select code
//   - C*_DEFAULT   : default half-period lengths for a 25 MHz clock
//   - cnt_width()  : counter width for a divider of a given half-period
package led_blinker_pkg;

   typedef enum logic [1:0] {
      SEL_100HZ = 2'b00,
      SEL_50HZ  = 2'b01,
      SEL_10HZ  = 2'b10,
      SEL_1HZ   = 2'b11
   } sel_e;

   localparam int C100_DEFAULT = 125000;
   localparam int C50_DEFAULT  = 250000;
   localparam int C10_DEFAULT  = 1250000;
   localparam int C1_DEFAULT   = 12500000;

   // The counter spans 0..c-1, so $clog2(c) bits suffice; c = 1 would give a
   // zero-width vector, hence the 1-bit floor.
   function automatic int cnt_width(input int c);
      return (c > 1) ? $clog2(c) : 1;
   endfunction

endpackage

// File: rtl/led_blinker_toggle_divider.sv
// Free-running toggle divider: a 50% duty square wave with a period of
// 2*HALF_PERIOD clock cycles. HALF_PERIOD must be >= 1.
// Ports:
//   i_clock  - system clock, rising-edge active
//   i_reset  - asynchronous active-high reset (counter and toggle cleared)
//   o_toggle - registered square wave output
module toggle_divider
   import led_blinker_pkg::*;
#(
   parameter int HALF_PERIOD = 1
) (
   input  logic i_clock,
   input  logic i_reset,
   output logic o_toggle
);

   localparam int              CW   = cnt_width(HALF_PERIOD);
   localparam logic [CW-1:0]   LAST = CW'(HALF_PERIOD - 1);

   logic [CW-1:0] count;

   // With HALF_PERIOD = 1 the counter sits at 0 == LAST, so the toggle
   // inverts on every edge.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         count    <= '0;
         o_toggle <= 1'b0;
      end else if (count == LAST) begin
         count    <= '0;
         o_toggle <= ~o_toggle;
      end else begin
         count    <= count + 1'b1;
      end
   end

endmodule

// File: rtl/led_blinker.sv
// LED blinker: four free-running toggle dividers (100/50/10/1 Hz), one
// picked by the switch code and gated by the enable input.
// Ports:
//   i_clock     - system clock, rising-edge active
//   i_reset     - asynchronous active-high reset
//   i_enable    - 1 = LED may blink, 0 = LED forced off
//   i_switch_1  - frequency select MSB
//   i_switch_2  - frequency select LSB
//   o_led_drive - LED drive, 1 = on
// Switches and enable are used raw; any synchronising/debouncing is done
// outside this block. The output path after the toggles is combinational,
// so selection and enable changes take effect in the same cycle.
module led_blinker
   import led_blinker_pkg::*;
#(
   parameter int c100 = C100_DEFAULT,
   parameter int c50  = C50_DEFAULT,
   parameter int c10  = C10_DEFAULT,
   parameter int c1   = C1_DEFAULT
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_enable,
   input  logic i_switch_1,
   input  logic i_switch_2,
   output logic o_led_drive
);

   logic tgl_100;
   logic tgl_50;
   logic tgl_10;
   logic tgl_1;
   sel_e sel;
   logic sel_toggle;

   toggle_divider #(.HALF_PERIOD(c100)) u_div_100 (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .o_toggle (tgl_100)
   );

   toggle_divider #(.HALF_PERIOD(c50)) u_div_50 (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .o_toggle (tgl_50)
   );

   toggle_divider #(.HALF_PERIOD(c10)) u_div_10 (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .o_toggle (tgl_10)
   );

   toggle_divider #(.HALF_PERIOD(c1)) u_div_1 (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .o_toggle (tgl_1)
   );

   assign sel = sel_e'({i_switch_1, i_switch_2});

   // Dividers are never restarted on a selection change; switching simply
   // picks up whatever phase the new divider is in.
   always_comb begin
      sel_toggle = 1'b0;
      case (sel)
         SEL_100HZ: sel_toggle = tgl_100;
         SEL_50HZ:  sel_toggle = tgl_50;
         SEL_10HZ:  sel_toggle = tgl_10;
         SEL_1HZ:   sel_toggle = tgl_1;
         default:   sel_toggle = 1'b0;
      endcase
   end

   assign o_led_drive = i_enable & sel_toggle;

endmodule

// File: tb/tb_led_blinker.sv
module tb_led_blinker;

   logic clk;
   logic rst;
   logic en;
   logic sw1;
   logic sw2;
   logic led;
   logic led_min;

   int n_cmp;
   int n_bad;
   int n;          // rising edges since the last reset release

   typedef struct {
      logic [1:0] sw;
      int         half;
   } run_vec_t;

   run_vec_t runs[4];

   led_blinker #(.c100(10), .c50(20), .c10(50), .c1(100)) dut (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_enable    (en),
      .i_switch_1  (sw1),
      .i_switch_2  (sw2),
      .o_led_drive (led)
   );

   led_blinker #(.c100(1), .c50(20), .c10(50), .c1(100)) dut_min (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_enable    (en),
      .i_switch_1  (sw1),
      .i_switch_2  (sw2),
      .o_led_drive (led_min)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   // Ideal toggle level after n edges for half-period c.
   function automatic logic lvl(input int edges, input int c);
      return ((edges / c) % 2) == 1;
   endfunction

   task automatic chk(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (edge %0d): got %b, expected %b", name, n, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      n++;
   endtask

   // Assert reset mid-cycle, check the output drops at once, then release
   // mid-cycle so the next rising edge is edge 1.
   task automatic do_reset(input string name);
      #5;
      rst = 1'b1;
      #1;
      chk({name, "_async_low"}, led, 1'b0);
      tick();
      chk({name, "_held_low"}, led, 1'b0);
      #10;
      rst = 1'b0;
      n = 0;
   endtask

   initial begin
      int hmin, hmax, lmin, lmax, len;
      logic prev;
      bit first;

      n_cmp = 0;
      n_bad = 0;
      n     = 0;

      runs[0] = '{sw: 2'b00, half: 10};
      runs[1] = '{sw: 2'b01, half: 20};
      runs[2] = '{sw: 2'b10, half: 50};
      runs[3] = '{sw: 2'b11, half: 100};

      // Test 1: reset and first periods of the 100 Hz wave
      en  = 1'b1;
      {sw1, sw2} = 2'b00;
      rst = 1'b1;
      #5;
      chk("reset_led", led, 1'b0);
      chk("reset_led_min", led_min, 1'b0);
      tick();
      tick();
      chk("reset_held", led, 1'b0);
      #10;
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 35; i++) begin
         tick();
         chk("t1_wave", led, lvl(n, 10));
         chk("t6_min_param", led_min, lvl(n, 1));
      end

      // Test 2: enable gating
      en = 1'b0;
      #1;
      chk("t2_disable_now", led, 1'b0);
      for (int i = 0; i < 200; i++) begin
         tick();
         chk("t2_gated", led, 1'b0);
      end
      en = 1'b1;
      #1;
      chk("t2_enable_now", led, lvl(n, 10));
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("t2_after_enable", led, lvl(n, 10));
      end

      // Test 3: run lengths per select code
      for (int v = 0; v < 4; v++) begin
         {sw1, sw2} = runs[v].sw;
         #1;
         hmin = 1 << 30; hmax = 0; lmin = 1 << 30; lmax = 0;
         len = 0; first = 1'b1; prev = led;
         for (int i = 0; i < 1000; i++) begin
            tick();
            if (led == prev) begin
               len++;
            end else begin
               if (!first) begin
                  if (prev) begin
                     if (len < hmin) hmin = len;
                     if (len > hmax) hmax = len;
                  end else begin
                     if (len < lmin) lmin = len;
                     if (len > lmax) lmax = len;
                  end
               end
               first = 1'b0;
               prev  = led;
               len   = 1;
            end
         end
         chk_int($sformatf("t3_sw%02b_high_min", runs[v].sw), hmin, runs[v].half);
         chk_int($sformatf("t3_sw%02b_high_max", runs[v].sw), hmax, runs[v].half);
         chk_int($sformatf("t3_sw%02b_low_min", runs[v].sw), lmin, runs[v].half);
         chk_int($sformatf("t3_sw%02b_low_max", runs[v].sw), lmax, runs[v].half);
      end

      // Test 4: select change mid-period
      {sw1, sw2} = 2'b00;
      do_reset("t4_reset");
      for (int i = 0; i < 15; i++) tick();
      chk("t4_before_switch", led, 1'b1);
      {sw1, sw2} = 2'b11;
      #1;
      chk("t4_switch_now", led, 1'b0);
      while (n < 99) begin
         tick();
         chk("t4_1hz_low", led, 1'b0);
      end
      tick();
      chk("t4_1hz_rise", led, 1'b1);

      // Test 5: asynchronous reset mid-run
      {sw1, sw2} = 2'b00;
      do_reset("t5_pre_reset");
      for (int i = 0; i < 37; i++) tick();
      chk("t5_edge37", led, 1'b1);
      do_reset("t5_mid_reset");
      for (int i = 0; i < 25; i++) begin
         tick();
         chk("t5_restart", led, lvl(n, 10));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
